pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 The block SHALL have a single clock and a synchronous active-low reset: clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active low.
REQ-005 rs1_d, rs2_d  input  REG_ADDR_W  source registers of the instruction in decode.
REQ-006 rs1_e, rs2_e, rd_e  input  REG_ADDR_W  sources and destination in execute.
REQ-007 rd_m, rd_w  input  REG_ADDR_W  destinations in memory and writeback.
REQ-008 regwrite_e, regwrite_m, regwrite_w  input  1  the stage's instruction writes rd.
REQ-009 memread_e  input  1  load in execute.
REQ-010 branch_taken_e  input  1  control redirect resolved in execute.
REQ-011 mc_start_e  input  1  multicycle op (mul/div) in execute, level.
REQ-012 mc_done  input  1  multicycle unit result valid this cycle.
REQ-013 dmem_req_m, dmem_ready_m  input  1  data-memory request in memory stage, and its completion.
REQ-014 stall_f, stall_d, stall_e, stall_m  output  1  hold the PC / IF-ID / ID-EX / EX-MEM register; 1 = hold; drives the pipeline register enable directly.
REQ-015 flush_d, flush_e, flush_m, flush_w  output  1  clear the IF-ID / ID-EX / EX-MEM / MEM-WB register to a bubble; 1 = clear.
REQ-016 fwd_a_e, fwd_b_e  output  2  forwarding selects: 00 register file, 01 writeback, 10 memory.
REQ-017 ctrl_state  output  2  current FSM state: 00 RUN, 01 MC_WAIT, 10 MEM_WAIT.
REQ-018 stall_cnt  output  CNT_W  count of cycles with stall_f = 1.

Function
REQ-019 A "match" SHALL mean: equal addresses, writer's regwrite = 1, address != 0.
REQ-020 The FSM SHALL have states RUN, MC_WAIT and MEM_WAIT; all stall/flush outputs SHALL be combinational from state and inputs.
REQ-021 In RUN with dmem_req_m = 1 and dmem_ready_m = 0: stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1; all other flushes = 0; next state MEM_WAIT; this has the highest priority.
REQ-022 In MEM_WAIT: the same outputs as REQ-021 while dmem_ready_m = 0; when dmem_ready_m = 1: no stall and no flush that cycle, next state RUN.
REQ-023 In RUN, if there is no memory wait and branch_taken_e = 1: flush_d = flush_e = 1, no stalls; this suppresses load-use and RAW stalls in the same cycle.
REQ-024 In RUN, if there is no memory wait or branch and mc_start_e = 1 with mc_done = 0: stall_f, stall_d, stall_e = 1; flush_m = 1; next state MC_WAIT.
REQ-025 If mc_start_e = 1 and mc_done = 1 in the same RUN cycle, the state SHALL remain RUN with no stall.
REQ-026 In MC_WAIT: the outputs of REQ-024 while mc_done = 0; when mc_done = 1: no stall that cycle, next state RUN; branch_taken_e is ignored in MC_WAIT.
REQ-027 Load-use: in RUN, with no higher-priority event, a match of rd_e against rs1_d or rs2_d while memread_e = 1 SHALL assert stall_f, stall_d and flush_e for that cycle only.
REQ-028 While any stall is asserted in MEM_WAIT or MC_WAIT, flushes of stalled registers SHALL be 0; deferred branch and multicycle events are acted on after return to RUN, when the held inputs reassert.
REQ-029 stall_cnt SHALL increment by 1 each cycle stall_f = 1 and saturate at all-ones without wrapping.

Reset
REQ-030 While rst = 0 at a clock edge: state becomes RUN and stall_cnt becomes 0.
REQ-031 While rst = 0: all stall outputs = 0, flush_d through flush_w = 1, fwd selects = 00.
REQ-032 Reset asserted in MC_WAIT or MEM_WAIT SHALL abort the wait with no residual stall after reset is released.

Configuration
REQ-033 Macro FORWARDING_EN defined: fwd_a_e = 10 on a match of rd_m with rs1_e, else 01 on a match of rd_w, else 00; fwd_b_e is the same for rs2_e; the memory stage wins when both match.
REQ-034 Macro FORWARDING_EN undefined: fwd selects are tied to 00, and in RUN any match of rd_e or rd_m against rs1_d or rs2_d is handled as in REQ-027 (regardless of memread_e); the register file writes through, so rd_w never stalls.

Verification
REQ-035 Load-use: memread_e = 1, rd_e = 5, rs1_d = 5 -> one cycle of stall_f = stall_d = flush_e = 1, stall_cnt increments by 1.
REQ-036 Branch plus load-use in the same cycle: branch_taken_e = 1 -> flush_d = flush_e = 1, stall_f = 0.
REQ-037 Multicycle op: mc_start_e = 1 with mc_done after 4 cycles -> ctrl_state = 01 for 4 cycles, stalls released on the mc_done cycle, then RUN.
REQ-038 Memory wait overlapping a multicycle op: dmem_ready_m low for 3 cycles with mc_start_e = 1 -> MEM_WAIT first, then MC_WAIT.
REQ-039 Forwarding (FORWARDING_EN defined): rd_m = rd_w = rs1_e = 7 -> fwd_a_e = 10; rd_m = 0 with rs1_e = 0 -> fwd_a_e = 00.
REQ-040 Saturation and reset: CNT_W = 4 with 20 stall cycles -> stall_cnt = 15; rst = 0 in MC_WAIT -> RUN, and all flushes = 1 while reset is held.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for a 5-stage pipeline.
// Define FORWARDING_EN to enable EX-stage operand forwarding (otherwise RAW hazards stall).
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_e,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  memread_e,
  input  logic                  branch_taken_e,
  input  logic                  mc_start_e,
  input  logic                  mc_done,
  input  logic                  dmem_req_m,
  input  logic                  dmem_ready_m,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic                  flush_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, MC_WAIT = 2'b01, MEM_WAIT = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_wait, hazard;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  function automatic logic match(input logic [REG_ADDR_W-1:0] src, input logic [REG_ADDR_W-1:0] dst,
                                 input logic we);
    return we && (src == dst) && (dst != '0);
  endfunction
  assign mem_wait = dmem_req_m & ~dmem_ready_m;
`ifdef FORWARDING_EN
  assign hazard = memread_e & (match(rs1_d, rd_e, regwrite_e) | match(rs2_d, rd_e, regwrite_e));
  assign fwd_a_raw = match(rs1_e, rd_m, regwrite_m) ? 2'b10 : match(rs1_e, rd_w, regwrite_w) ? 2'b01 : 2'b00;
  assign fwd_b_raw = match(rs2_e, rd_m, regwrite_m) ? 2'b10 : match(rs2_e, rd_w, regwrite_w) ? 2'b01 : 2'b00;
`else
  // Without forwarding every in-flight writer stalls decode; the register file writes through for WB.
  logic unused_fwd;
  assign unused_fwd = ^{rs1_e, rs2_e, rd_w, regwrite_w, memread_e};
  assign hazard = match(rs1_d, rd_e, regwrite_e) | match(rs2_d, rd_e, regwrite_e) |
                  match(rs1_d, rd_m, regwrite_m) | match(rs2_d, rd_m, regwrite_m);
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;
`endif
  assign fwd_a_e = rst ? fwd_a_raw : 2'b00;
  assign fwd_b_e = rst ? fwd_b_raw : 2'b00;
  assign ctrl_state = state_q;
  assign stall_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
    {flush_d, flush_e, flush_m, flush_w} = 4'b0000;
    if (!rst) begin
      {flush_d, flush_e, flush_m, flush_w} = 4'b1111;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_wait) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_w = 1'b1;
            state_d = MEM_WAIT;
          end else if (branch_taken_e) begin
            {flush_d, flush_e} = 2'b11;
          end else if (mc_start_e) begin
            if (!mc_done) begin
              {stall_f, stall_d, stall_e} = 3'b111;
              flush_m = 1'b1;
              state_d = MC_WAIT;
            end
          end else if (hazard) begin
            {stall_f, stall_d} = 2'b11;
            flush_e = 1'b1;
          end
        end
        MC_WAIT: begin
          if (!mc_done) begin
            {stall_f, stall_d, stall_e} = 3'b111;
            flush_m = 1'b1;
          end else state_d = RUN;
        end
        MEM_WAIT: begin
          if (!dmem_ready_m) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_w = 1'b1;
          end else state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    cnt_d = (stall_f && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic regwrite_e, regwrite_m, regwrite_w, memread_e, branch_taken_e;
  logic mc_start_e, mc_done, dmem_req_m, dmem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic [1:0] fwd_a_e, fwd_b_e, ctrl_state;
  logic [15:0] stall_cnt;
  logic s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_flush_m, s_flush_w;
  logic [1:0] s_fwd_a_e, s_fwd_b_e, s_ctrl_state;
  logic [3:0] s_stall_cnt;
  logic [3:0] st, fl;
  int errors = 0, checks = 0;
  logic [15:0] exp_cnt;
  assign st = {stall_f, stall_d, stall_e, stall_m};
  assign fl = {flush_d, flush_e, flush_m, flush_w};
  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .memread_e(memread_e), .branch_taken_e(branch_taken_e),
    .mc_start_e(mc_start_e), .mc_done(mc_done), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt));

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .memread_e(memread_e), .branch_taken_e(branch_taken_e),
    .mc_start_e(mc_start_e), .mc_done(mc_done), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_m(s_flush_m), .flush_w(s_flush_w),
    .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .ctrl_state(s_ctrl_state), .stall_cnt(s_stall_cnt));

  task automatic idle();
    rst = 1'b1;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_e, regwrite_m, regwrite_w, memread_e, branch_taken_e} = '0;
    {mc_start_e, mc_done, dmem_req_m, dmem_ready_m} = '0;
  endtask

  task automatic tick(input bit sf);
    @(posedge clk);
    #1;
    if (sf) exp_cnt++;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    dmem_req_m = 1'b1;
    mc_start_e = 1'b1;
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL rst_stall got=%b exp=0000", st); end
    checks++; if (fl !== 4'b1111) begin errors++; $display("FAIL rst_flush got=%b exp=1111", fl); end
    checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got=%b exp=0000", {fwd_a_e, fwd_b_e}); end
    tick(0);
    tick(0);
    exp_cnt = '0;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL rst_state got=%b exp=00", ctrl_state); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    idle();
    #2;
    checks++; if ({st, fl} !== 8'h00) begin errors++; $display("FAIL rst_release got=%b exp=00000000", {st, fl}); end
    tick(0);
  endtask

  task automatic test_load_use();
    idle();
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    #2;
    checks++; if (st !== 4'b1100) begin errors++; $display("FAIL lu_stall got=%b exp=1100", st); end
    checks++; if (fl !== 4'b0100) begin errors++; $display("FAIL lu_flush got=%b exp=0100", fl); end
    tick(1);
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL lu_state got=%b exp=00", ctrl_state); end
    rs1_d = 5'd0; rs2_d = 5'd5;
    #2;
    checks++; if (st !== 4'b1100) begin errors++; $display("FAIL lu_rs2 got=%b exp=1100", st); end
    tick(1);
    rd_e = 5'd0; rs2_d = 5'd0;
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL lu_r0 got=%b exp=0000", st); end
    tick(0);
    rd_e = 5'd5; rs2_d = 5'd5; regwrite_e = 1'b0;
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL lu_nowrite got=%b exp=0000", st); end
    tick(0);
  endtask

  task automatic test_branch();
    idle();
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; branch_taken_e = 1'b1;
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL br_stall got=%b exp=0000", st); end
    checks++; if (fl !== 4'b1100) begin errors++; $display("FAIL br_flush got=%b exp=1100", fl); end
    tick(0);
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL br_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_multicycle();
    idle();
    mc_start_e = 1'b1;
    #2;
    checks++; if (st !== 4'b1110) begin errors++; $display("FAIL mc_start_stall got=%b exp=1110", st); end
    checks++; if (fl !== 4'b0010) begin errors++; $display("FAIL mc_start_flush got=%b exp=0010", fl); end
    tick(1);
    branch_taken_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ctrl_state !== 2'b01) begin errors++; $display("FAIL mc_wait_state[%0d] got=%b exp=01", i, ctrl_state); end
      checks++; if ({st, fl} !== 8'b1110_0010) begin errors++; $display("FAIL mc_wait_out[%0d] got=%b exp=11100010", i, {st, fl}); end
      tick(1);
    end
    mc_done = 1'b1;
    branch_taken_e = 1'b0;
    #2;
    checks++; if (ctrl_state !== 2'b01) begin errors++; $display("FAIL mc_done_state got=%b exp=01", ctrl_state); end
    checks++; if ({st, fl} !== 8'h00) begin errors++; $display("FAIL mc_done_out got=%b exp=00000000", {st, fl}); end
    tick(0);
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL mc_back_run got=%b exp=00", ctrl_state); end
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL mc_same_cycle got=%b exp=0000", st); end
    tick(0);
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL mc_same_state got=%b exp=00", ctrl_state); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL mc_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_mem_mc_overlap();
    idle();
    dmem_req_m = 1'b1; mc_start_e = 1'b1;
    #2;
    checks++; if ({st, fl} !== 8'b1111_0001) begin errors++; $display("FAIL mem_enter got=%b exp=11110001", {st, fl}); end
    tick(1);
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (ctrl_state !== 2'b10) begin errors++; $display("FAIL mem_state[%0d] got=%b exp=10", i, ctrl_state); end
      checks++; if ({st, fl} !== 8'b1111_0001) begin errors++; $display("FAIL mem_out[%0d] got=%b exp=11110001", i, {st, fl}); end
      tick(1);
    end
    dmem_ready_m = 1'b1;
    #2;
    checks++; if ({st, fl} !== 8'h00) begin errors++; $display("FAIL mem_ready got=%b exp=00000000", {st, fl}); end
    tick(0);
    dmem_req_m = 1'b0; dmem_ready_m = 1'b0;
    #2;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL mem_back_run got=%b exp=00", ctrl_state); end
    checks++; if (st !== 4'b1110) begin errors++; $display("FAIL mem_then_mc got=%b exp=1110", st); end
    tick(1);
    checks++; if (ctrl_state !== 2'b01) begin errors++; $display("FAIL mem_mc_state got=%b exp=01", ctrl_state); end
    mc_done = 1'b1;
    tick(0);
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL mem_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_hazard_mode();
    idle();
`ifdef FORWARDING_EN
    regwrite_m = 1'b1; regwrite_w = 1'b1; rd_m = 5'd7; rd_w = 5'd7; rs1_e = 5'd7; rs2_e = 5'd7;
    #2;
    checks++; if (fwd_a_e !== 2'b10) begin errors++; $display("FAIL fwd_a_mem got=%b exp=10", fwd_a_e); end
    checks++; if (fwd_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_mem got=%b exp=10", fwd_b_e); end
    regwrite_m = 1'b0;
    #2;
    checks++; if (fwd_a_e !== 2'b01) begin errors++; $display("FAIL fwd_a_wb got=%b exp=01", fwd_a_e); end
    regwrite_m = 1'b1; rd_m = 5'd0; rs1_e = 5'd0; rd_w = 5'd3; rs2_e = 5'd3;
    #2;
    checks++; if (fwd_a_e !== 2'b00) begin errors++; $display("FAIL fwd_a_r0 got=%b exp=00", fwd_a_e); end
    checks++; if (fwd_b_e !== 2'b01) begin errors++; $display("FAIL fwd_b_wb got=%b exp=01", fwd_b_e); end
    rd_m = 5'd9; rs1_d = 5'd9; regwrite_e = 1'b1; rd_e = 5'd4; rs2_d = 5'd4;
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL fwd_nostall got=%b exp=0000", st); end
    tick(0);
`else
    regwrite_m = 1'b1; rd_m = 5'd9; rs2_d = 5'd9; rs1_e = 5'd9; regwrite_w = 1'b1; rd_w = 5'd9; rs2_e = 5'd9;
    #2;
    checks++; if (st !== 4'b1100) begin errors++; $display("FAIL raw_m_stall got=%b exp=1100", st); end
    checks++; if (fl !== 4'b0100) begin errors++; $display("FAIL raw_m_flush got=%b exp=0100", fl); end
    checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) begin errors++; $display("FAIL raw_fwd got=%b exp=0000", {fwd_a_e, fwd_b_e}); end
    tick(1);
    regwrite_m = 1'b0; regwrite_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; rs2_d = 5'd0;
    #2;
    checks++; if (st !== 4'b1100) begin errors++; $display("FAIL raw_e_stall got=%b exp=1100", st); end
    tick(1);
    regwrite_e = 1'b0; rd_w = 5'd6; rs1_d = 5'd6;
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL raw_w_nostall got=%b exp=0000", st); end
    tick(0);
`endif
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL hz_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_reset_in_wait();
    idle();
    mc_start_e = 1'b1;
    tick(1);
    checks++; if (ctrl_state !== 2'b01) begin errors++; $display("FAIL rw_enter got=%b exp=01", ctrl_state); end
    rst = 1'b0;
    #2;
    checks++; if ({st, fl} !== 8'b0000_1111) begin errors++; $display("FAIL rw_held got=%b exp=00001111", {st, fl}); end
    tick(0);
    exp_cnt = '0;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL rw_state got=%b exp=00", ctrl_state); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rw_cnt got=%0d exp=0", stall_cnt); end
    idle();
    #2;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL rw_residual got=%b exp=0000", st); end
    tick(0);
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL rw_after got=%b exp=00", ctrl_state); end
  endtask

  task automatic test_saturation();
    idle();
    rst = 1'b0;
    tick(0);
    exp_cnt = '0;
    rst = 1'b1;
    checks++; if (s_stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_zero got=%0d exp=0", s_stall_cnt); end
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    for (int i = 0; i < 10; i++) tick(1);
    checks++; if (s_stall_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d exp=10", s_stall_cnt); end
    for (int i = 0; i < 10; i++) tick(1);
    checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", s_stall_cnt); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    idle();
    tick(0);
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_load_use();
    test_branch();
    test_multicycle();
    test_mem_mc_overlap();
    test_hazard_mode();
    test_reset_in_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
